// File: rtl/baseband_pkg.sv
// rtl/baseband_pkg.sv - shared baseband types, constants and gain decode
package baseband_pkg;

  // Transmit conditioner sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } tx_state_t;

  // Bit of the audio threshold/control word that enables the path
  localparam int THR_EN_BIT = 30;

  // Priority decode of the gain-select bits into a left-shift amount.
  // The TX gain undoes the RX attenuation, so the mapping mirrors it.
  function automatic logic [3:0] gain_shift(input logic [4:0] thr);
    logic [3:0] k;
    if (thr[4])      k = 4'd0;
    else if (thr[3]) k = 4'd1;
    else if (thr[2]) k = 4'd2;
    else if (thr[1]) k = 4'd3;
    else if (thr[0]) k = 4'd8;
    else             k = 4'd0;
    return k;
  endfunction

endpackage

// File: rtl/audio_tx_fifo.sv
// rtl/audio_tx_fifo.sv - synchronous elastic FIFO with flush
module audio_tx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_nx;

  // Qualify requests: no write when full, no read when empty, flush wins
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    count_nx = count;
    if (do_push && !do_pop)
      count_nx = count + 1'b1;
    else if (do_pop && !do_push)
      count_nx = count - 1'b1;
  end

  assign rdata = mem[rd_ptr];

  // Storage array; no reset needed since pointers define validity
  always_ff @(posedge clk_in) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == DEPTH_C);
      empty <= (count_nx == '0);
    end
  end

endmodule

// File: rtl/audio_tx_cond.sv
// rtl/audio_tx_cond.sv - TX audio scaler, elastic FIFO, strobe server and power meter
module audio_tx_cond
  import baseband_pkg::*;
#(
  parameter int AUDIO_WIDTH  = 21,
  parameter int MOD_WIDTH    = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int POW_WIN_LOG2 = 6
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AUDIO_WIDTH-1:0] s_data,
  input  logic [30:0]            audio_thr,
  input  logic                   mod_strobe,
  output logic                   mod_valid,
  output logic [MOD_WIDTH-1:0]   mod_data,
  output logic [31:0]            power,
  output logic                   underrun,
  output logic                   sat_flag
);

  localparam int SW = AUDIO_WIDTH + 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = 2 * MOD_WIDTH;
  localparam logic [CW-1:0]        PRIME_LEVEL = CW'(FIFO_DEPTH / 2);
  localparam logic signed [SW-1:0] MOD_MAX = SW'((2 ** (MOD_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MOD_MIN = -(SW'(2 ** (MOD_WIDTH - 1)));

  tx_state_t              state;
  tx_state_t              state_nx;
  logic                   enable;
  logic                   enable_q;
  logic                   en_fall;
  logic [3:0]             k;
  logic signed [SW-1:0]   ext;
  logic signed [SW-1:0]   scaled;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [MOD_WIDTH-1:0]   wdata;
  logic                   push;
  logic                   pop;
  logic                   flush;
  logic                   starve;
  logic [MOD_WIDTH-1:0]   fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic signed [QW-1:0]   sq_in;
  logic signed [QW-1:0]   sq;
  logic [31:0]            sq32;
  logic [31:0]            acc;
  logic [POW_WIN_LOG2-1:0] win_cnt;

  assign enable  = audio_thr[THR_EN_BIT];
  assign en_fall = enable_q && !enable;

  // Gain shift and saturation of the incoming sample to modulator width
  always_comb begin
    k      = gain_shift(audio_thr[4:0]);
    ext    = SW'($signed(s_data));
    scaled = (ext <<< k) >>> 9;
    sat_hi = (scaled > MOD_MAX);
    sat_lo = (scaled < MOD_MIN);
    if (sat_hi)
      wdata = MOD_MAX[MOD_WIDTH-1:0];
    else if (sat_lo)
      wdata = MOD_MIN[MOD_WIDTH-1:0];
    else
      wdata = scaled[MOD_WIDTH-1:0];
  end

  // Sequencer state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state and handshake decode; dropping enable always returns to IDLE
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    starve   = 1'b0;
    flush    = !enable || (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        s_ready = enable && !fifo_full;
        if (fifo_count >= PRIME_LEVEL)
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        s_ready = enable && !fifo_full;
        pop     = mod_strobe && !fifo_empty;
        starve  = mod_strobe && fifo_empty;
        if (starve)
          state_nx = ST_PRIME;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    push = s_valid && s_ready;
    if (!enable)
      state_nx = ST_IDLE;
  end

  audio_tx_fifo #(
    .WIDTH (MOD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Serve every strobe one clock later; outside RUN or when starved the word is 0
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mod_valid <= 1'b0;
      mod_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      mod_valid <= mod_strobe;
      underrun  <= starve;
      if (mod_strobe)
        mod_data <= pop ? fifo_rdata : '0;
    end
  end

  // Enable edge tracking and sticky saturation flag cleared when enable drops
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      enable_q <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      enable_q <= enable;
      if (en_fall)
        sat_flag <= 1'b0;
      else if (push && (sat_hi || sat_lo))
        sat_flag <= 1'b1;
    end
  end

  assign sq_in = QW'($signed(mod_data));
  assign sq    = sq_in * sq_in;
  assign sq32  = {{(32 - QW){1'b0}}, sq};

  // Windowed power: accumulate squares of served words, publish at window end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
      power   <= '0;
    end else if (en_fall) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (mod_valid) begin
      win_cnt <= win_cnt + 1'b1;
      if (win_cnt == '1) begin
        power <= acc + sq32;
        acc   <= '0;
      end else begin
        acc <= acc + sq32;
      end
    end
  end

endmodule

// File: tb/tb_audio_tx_cond.sv
// tb/tb_audio_tx_cond.sv - directed self-checking bench for audio_tx_cond
module tb_audio_tx_cond;

  logic        clk_in;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [20:0] s_data;
  logic [30:0] audio_thr;
  logic        mod_strobe;
  logic        mod_valid;
  logic [11:0] mod_data;
  logic [31:0] power;
  logic        underrun;
  logic        sat_flag;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [30:0] EN = 31'h4000_0000;

  audio_tx_cond dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .audio_thr  (audio_thr),
    .mod_strobe (mod_strobe),
    .mod_valid  (mod_valid),
    .mod_data   (mod_data),
    .power      (power),
    .underrun   (underrun),
    .sat_flag   (sat_flag)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step(input logic v, input logic signed [20:0] d, input logic strobe);
    s_valid    = v;
    s_data     = d;
    mod_strobe = strobe;
    tick();
    s_valid    = 1'b0;
    mod_strobe = 1'b0;
  endtask

  task automatic serve(input logic v, input logic signed [20:0] d, input string tag,
                       input int exp_data, input logic exp_ur);
    step(v, d, 1'b1);
    chk({tag, "_valid"}, 32'(mod_valid), 1);
    chk({tag, "_data"}, $signed(mod_data), exp_data);
    chk({tag, "_underrun"}, 32'(underrun), 32'(exp_ur));
  endtask

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    mod_strobe = 1'b0;
    audio_thr  = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_mod_valid", 32'(mod_valid), 0);
    chk("rst_mod_data", $signed(mod_data), 0);
    chk("rst_power", power, 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sat_flag", 32'(sat_flag), 0);
    rst = 1'b0;

    // Unity-ish gain: 1024 >>> 9 = 2
    audio_thr = EN | 31'h10;
    tick();
    chk("t1_ready", 32'(s_ready), 1);
    repeat (4) step(1'b1, 21'sd1024, 1'b0);
    serve(1'b0, '0, "t1_prime", 0, 1'b0);
    for (int i = 0; i < 4; i++) serve(1'b1, 21'sd1024, "t1_pushpop", 2, 1'b0);
    for (int i = 0; i < 4; i++) serve(1'b0, '0, "t1_drain", 2, 1'b0);
    chk("t1_power", power, 0);
    audio_thr = '0;
    tick();
    chk("t1_idle_ready", 32'(s_ready), 0);

    // Gain 8 scaling, saturation and floor
    audio_thr = EN | 31'h01;
    tick();
    step(1'b1, 21'sd1000, 1'b0);
    chk("t2_sat_clear", 32'(sat_flag), 0);
    step(1'b1, 21'sd10000, 1'b0);
    chk("t2_sat_set", 32'(sat_flag), 1);
    step(1'b1, -21'sd10000, 1'b0);
    audio_thr = EN;
    step(1'b1, -21'sd1, 1'b0);
    tick();
    serve(1'b0, '0, "t2_500", 500, 1'b0);
    serve(1'b0, '0, "t2_sat_hi", 2047, 1'b0);
    serve(1'b0, '0, "t2_sat_lo", -2048, 1'b0);
    serve(1'b0, '0, "t2_floor", -1, 1'b0);
    audio_thr = '0;
    tick();
    chk("t2_sat_drop", 32'(sat_flag), 0);

    // Fill to full, reject when full, simultaneous push/pop
    audio_thr = EN | 31'h10;
    tick();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 21'(512 * (i + 1)), 1'b0);
      if (i == 6) chk("t3_ready_7", 32'(s_ready), 1);
      if (i == 7) chk("t3_ready_8", 32'(s_ready), 0);
    end
    step(1'b1, 21'sd10240, 1'b0);
    chk("t3_count_full", 32'(dut.u_fifo.count), 8);
    chk("t3_ready_full", 32'(s_ready), 0);
    serve(1'b0, '0, "t3_pop1", 1, 1'b0);
    chk("t3_count_7", 32'(dut.u_fifo.count), 7);
    chk("t3_ready_7b", 32'(s_ready), 1);
    serve(1'b1, 21'sd4608, "t3_pushpop", 2, 1'b0);
    chk("t3_count_same", 32'(dut.u_fifo.count), 7);
    for (int i = 3; i <= 9; i++) serve(1'b0, '0, "t3_drain", i, 1'b0);

    // Starvation: underrun, back to PRIME, refill
    for (int i = 10; i <= 13; i++) step(1'b1, 21'(512 * i), 1'b0);
    for (int i = 10; i <= 13; i++) serve(1'b0, '0, "t4_data", i, 1'b0);
    serve(1'b0, '0, "t4_underrun", 0, 1'b1);
    tick();
    chk("t4_ur_pulse", 32'(underrun), 0);
    chk("t4_valid_pulse", 32'(mod_valid), 0);
    serve(1'b0, '0, "t4_prime0", 0, 1'b0);
    for (int i = 14; i <= 16; i++) step(1'b1, 21'(512 * i), 1'b0);
    serve(1'b0, '0, "t4_prime3", 0, 1'b0);
    step(1'b1, 21'(512 * 17), 1'b0);
    serve(1'b0, '0, "t4_prime4", 0, 1'b0);
    serve(1'b0, '0, "t4_run", 14, 1'b0);

    // Power window: 64 words of 2 -> 256
    audio_thr = '0;
    tick();
    audio_thr = EN | 31'h10;
    tick();
    repeat (4) step(1'b1, 21'sd1024, 1'b0);
    tick();
    for (int i = 0; i < 64; i++) step(1'b1, 21'sd1024, 1'b1);
    chk("t5_before", power, 0);
    tick();
    chk("t5_win1", power, 256);
    for (int i = 0; i < 32; i++) step(1'b1, 21'sd1024, 1'b1);
    chk("t5_mid", power, 256);
    for (int i = 0; i < 32; i++) step(1'b1, 21'sd1024, 1'b1);
    tick();
    chk("t5_win2", power, 256);

    // Enable drop mid-RUN with 3 queued
    audio_thr = EN | 31'h01;
    step(1'b1, 21'sd10000, 1'b0);
    chk("t6_sat_set", 32'(sat_flag), 1);
    audio_thr = EN | 31'h10;
    serve(1'b0, '0, "t6_pop_a", 2, 1'b0);
    serve(1'b0, '0, "t6_pop_b", 2, 1'b0);
    chk("t6_count_3", 32'(dut.u_fifo.count), 3);
    audio_thr = '0;
    tick();
    chk("t6_ready", 32'(s_ready), 0);
    chk("t6_sat", 32'(sat_flag), 0);
    chk("t6_power", power, 256);
    chk("t6_count", 32'(dut.u_fifo.count), 0);
    chk("t6_empty", 32'(dut.u_fifo.empty), 1);
    serve(1'b0, '0, "t6_idle", 0, 1'b0);

    // Asynchronous reset mid-window
    audio_thr = EN | 31'h10;
    tick();
    repeat (3) step(1'b1, 21'sd1024, 1'b0);
    audio_thr = EN | 31'h01;
    step(1'b1, 21'sd10000, 1'b0);
    audio_thr = EN | 31'h10;
    tick();
    serve(1'b0, '0, "t7_pre", 2, 1'b0);
    chk("t7_pre_sat", 32'(sat_flag), 1);
    chk("t7_pre_ready", 32'(s_ready), 1);
    rst = 1'b1;
    #1;
    chk("t7_s_ready", 32'(s_ready), 0);
    chk("t7_mod_valid", 32'(mod_valid), 0);
    chk("t7_mod_data", $signed(mod_data), 0);
    chk("t7_power", power, 0);
    chk("t7_underrun", 32'(underrun), 0);
    chk("t7_sat_flag", 32'(sat_flag), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
